// File: rtl/cpu_control_pkg.sv
// ============================================================================
// cpu_control_pkg : shared opcodes, step encodings and instr field positions
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_control_pkg;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // instr = {opcode[5:4], rx[3:2], ry[1:0]}
    localparam int OPC_LSB = 4;
    localparam int RX_LSB  = 2;
    localparam int RY_LSB  = 0;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    // add and sub share the upper opcode bit and take the 4-step ALU path
    function automatic logic is_alu(input logic [1:0] opc);
        return opc[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_control_dec_2to4.sv
// ============================================================================
// dec_2to4 : binary select to one-hot decoder with enable (all zero when off)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_2to4 #(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  en_i,
    output logic [2**SEL_W-1:0]   y_o
);

    always_comb begin
        y_o = '0;
        for (int i = 0; i < 2**SEL_W; i++) begin
            y_o[i] = en_i && (sel_i == i[SEL_W-1:0]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_control.sv
// ============================================================================
// cpu_control : multi-cycle sequencer for the 4-bit CPU (mv, mvi, add, sub)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control
    import cpu_control_pkg::*;
#(
    parameter int OPC_W = 2,
    parameter int SEL_W = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [OPC_W+2*SEL_W-1:0]     instr,
    output logic                         ir_load,
    output logic [2**SEL_W-1:0]          r_in,
    output logic [2**SEL_W-1:0]          r_out,
    output logic                         a_in,
    output logic                         g_in,
    output logic                         g_out,
    output logic                         din_out,
    output logic                         add_sub,
    output logic                         done
);

    localparam int INSTR_W = OPC_W + 2*SEL_W;

    step_e                 state_q, state_d;
    logic [INSTR_W-1:0]    ir_q, ir_d;

    logic [OPC_W-1:0]      opc;
    logic [SEL_W-1:0]      rx, ry;
    logic                  rin_en;
    logic                  rout_en;
    logic [SEL_W-1:0]      rout_sel;
    logic                  ir_load_raw;

    assign opc = ir_q[OPC_LSB +: OPC_W];
    assign rx  = ir_q[RX_LSB  +: SEL_W];
    assign ry  = ir_q[RY_LSB  +: SEL_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ir_load_raw = 1'b0;
        rin_en      = 1'b0;
        rout_en     = 1'b0;
        rout_sel    = rx;
        a_in        = 1'b0;
        g_in        = 1'b0;
        g_out       = 1'b0;
        din_out     = 1'b0;
        add_sub     = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            T0: begin
                ir_load_raw = run;
                if (run) begin
                    ir_d    = instr;
                    state_d = T1;
                end
            end
            T1: begin
                if (!is_alu(opc)) begin
                    rin_en  = 1'b1;
                    done    = 1'b1;
                    state_d = T0;
                    if (opc == OP_MV) begin
                        rout_en  = 1'b1;
                        rout_sel = ry;
                    end else begin
                        din_out = 1'b1;
                    end
                end else begin
                    rout_en  = 1'b1;
                    rout_sel = rx;
                    a_in     = 1'b1;
                    state_d  = T2;
                end
            end
            T2: begin
                rout_en  = 1'b1;
                rout_sel = ry;
                g_in     = 1'b1;
                add_sub  = opc[0];
                state_d  = T3;
            end
            T3: begin
                g_out   = 1'b1;
                rin_en  = 1'b1;
                done    = 1'b1;
                state_d = T0;
            end
        endcase
    end

    // Reset clears state asynchronously, but T0 would still pass run through
    assign ir_load = ir_load_raw & reset;

    dec_2to4 #(.SEL_W(SEL_W)) u_dec_rin (
        .sel_i (rx),
        .en_i  (rin_en),
        .y_o   (r_in)
    );

    dec_2to4 #(.SEL_W(SEL_W)) u_dec_rout (
        .sel_i (rout_sel),
        .en_i  (rout_en),
        .y_o   (r_out)
    );

endmodule

`default_nettype wire
